vliw_fwd_ctrl: RTL and testbench

Forwarding and load-use hazard controller for the four-lane STARBUG VLIW integer pipeline. It tracks destination registers of all four IEU lanes through the Execute, Memory and Writeback stages. Each cycle it produces, for every lane, the ForwardAE/ForwardBE mux controls and the per-operand lane-relative forward selects consumed by each lane's datapath. It also raises the bundle-wide load-use stall request to the hazard unit.

---
 rtl/vliw_fwd_ctrl_if.sv | 41 ++++
 rtl/vliw_fwd_ctrl.sv | 129 ++++++++++++
 tb/tb_vliw_fwd_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vliw_fwd_ctrl_if.sv
// Decode/hazard-unit side bundle of the STARBUG forwarding controller.
// StallCount exists only when VLIW_FWD_PERF_EN is defined.
interface vliw_fwd_ctrl_if #(
  parameter int NLANES = 4
);
  logic [NLANES-1:0][4:0] Rs1D;
  logic [NLANES-1:0][4:0] Rs2D;
  logic [NLANES-1:0][4:0] RdD;
  logic [NLANES-1:0]      RegWriteD;
  logic [NLANES-1:0]      LateResultD;
  logic                   StallE, FlushE, StallM, FlushM, StallW, FlushW;
  logic [NLANES-1:0][1:0] ForwardAE;
  logic [NLANES-1:0][1:0] ForwardBE;
  logic [NLANES-1:0][1:0] ForwardSelAE;
  logic [NLANES-1:0][1:0] ForwardSelBE;
  logic                   LoadUseStallD;
  logic                   MultiWriteErr;
`ifdef VLIW_FWD_PERF_EN
  logic [31:0]            StallCount;
`endif

  modport master (
    output Rs1D, Rs2D, RdD, RegWriteD, LateResultD,
    output StallE, FlushE, StallM, FlushM, StallW, FlushW,
`ifdef VLIW_FWD_PERF_EN
    input  StallCount,
`endif
    input  ForwardAE, ForwardBE, ForwardSelAE, ForwardSelBE,
    input  LoadUseStallD, MultiWriteErr
  );

  modport slave (
    input  Rs1D, Rs2D, RdD, RegWriteD, LateResultD,
    input  StallE, FlushE, StallM, FlushM, StallW, FlushW,
`ifdef VLIW_FWD_PERF_EN
    output StallCount,
`endif
    output ForwardAE, ForwardBE, ForwardSelAE, ForwardSelBE,
    output LoadUseStallD, MultiWriteErr
  );
endinterface

// File: rtl/vliw_fwd_ctrl.sv
// Four-lane forwarding / load-use controller: tracks rd through E/M/W and drives per-lane bypass selects.
// Define VLIW_FWD_PERF_EN to add the saturating StallCount load-use counter.
module vliw_fwd_ctrl #(
  parameter int NLANES = 4
) (
  input  logic           clk,
  input  logic           reset,
  vliw_fwd_ctrl_if.slave bus
);
  logic [NLANES-1:0][4:0] rs1_e_reg, rs2_e_reg, rd_e_reg, rd_m_reg, rd_w_reg;
  logic [NLANES-1:0]      rw_e_reg, late_e_reg, rw_m_reg, late_m_reg, rw_w_reg;
  logic                   load_use;
  logic                   multi_err;

  // Flush wins over stall in every stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs1_e_reg  <= '0;
      rs2_e_reg  <= '0;
      rd_e_reg   <= '0;
      rw_e_reg   <= '0;
      late_e_reg <= '0;
      rd_m_reg   <= '0;
      rw_m_reg   <= '0;
      late_m_reg <= '0;
      rd_w_reg   <= '0;
      rw_w_reg   <= '0;
    end else begin
      if (bus.FlushE) begin
        rs1_e_reg  <= '0;
        rs2_e_reg  <= '0;
        rd_e_reg   <= '0;
        rw_e_reg   <= '0;
        late_e_reg <= '0;
      end else if (!bus.StallE) begin
        rs1_e_reg  <= bus.Rs1D;
        rs2_e_reg  <= bus.Rs2D;
        rd_e_reg   <= bus.RdD;
        rw_e_reg   <= bus.RegWriteD;
        late_e_reg <= bus.LateResultD;
      end
      if (bus.FlushM) begin
        rd_m_reg   <= '0;
        rw_m_reg   <= '0;
        late_m_reg <= '0;
      end else if (!bus.StallM) begin
        rd_m_reg   <= rd_e_reg;
        rw_m_reg   <= rw_e_reg;
        late_m_reg <= late_e_reg;
      end
      if (bus.FlushW) begin
        rd_w_reg <= '0;
        rw_w_reg <= '0;
      end else if (!bus.StallW) begin
        rd_w_reg <= rd_m_reg;
        rw_w_reg <= rw_m_reg;
      end
    end
  end

  // Returns {forward, lane-relative select}; ascending scan lets the highest lane win.
  function automatic logic [3:0] pick(input logic [4:0] x, input logic [1:0] lane);
    logic       m_hit, w_hit;
    logic [1:0] m_src, w_src;
    m_hit = 1'b0;
    w_hit = 1'b0;
    m_src = lane;
    w_src = lane;
    for (int j = 0; j < NLANES; j++) begin
      if (x != 5'd0 && rw_m_reg[j] && !late_m_reg[j] && rd_m_reg[j] == x) begin
        m_hit = 1'b1;
        m_src = 2'(j);
      end
      if (x != 5'd0 && rw_w_reg[j] && rd_w_reg[j] == x) begin
        w_hit = 1'b1;
        w_src = 2'(j);
      end
    end
    if (m_hit)      pick = {2'b10, 2'(m_src - lane)};
    else if (w_hit) pick = {2'b01, 2'(w_src - lane)};
    else            pick = 4'b0000;
  endfunction

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign {bus.ForwardAE[gi], bus.ForwardSelAE[gi]} = pick(rs1_e_reg[gi], LANE);
    assign {bus.ForwardBE[gi], bus.ForwardSelBE[gi]} = pick(rs2_e_reg[gi], LANE);
  end

  // A late producer sitting in E cannot reach a D consumer in time.
  always_comb begin
    load_use = 1'b0;
    for (int j = 0; j < NLANES; j++) begin
      for (int i = 0; i < NLANES; i++) begin
        if (rw_e_reg[j] && late_e_reg[j] && rd_e_reg[j] != 5'd0 &&
            (rd_e_reg[j] == bus.Rs1D[i] || rd_e_reg[j] == bus.Rs2D[i]))
          load_use = 1'b1;
      end
    end
  end

  always_comb begin
    multi_err = 1'b0;
    for (int i = 0; i < NLANES; i++) begin
      for (int j = i + 1; j < NLANES; j++) begin
        if (rw_m_reg[i] && rw_m_reg[j] && rd_m_reg[i] != 5'd0 && rd_m_reg[i] == rd_m_reg[j])
          multi_err = 1'b1;
        if (rw_w_reg[i] && rw_w_reg[j] && rd_w_reg[i] != 5'd0 && rd_w_reg[i] == rd_w_reg[j])
          multi_err = 1'b1;
      end
    end
  end

  assign bus.LoadUseStallD = load_use;
  assign bus.MultiWriteErr = multi_err;

`ifdef VLIW_FWD_PERF_EN
  logic [31:0] stall_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count_reg <= '0;
    else if (load_use && stall_count_reg != 32'hFFFF_FFFF)
      stall_count_reg <= stall_count_reg + 32'd1;
  end

  assign bus.StallCount = stall_count_reg;
`endif
endmodule

// File: tb/tb_vliw_fwd_ctrl.sv
// Bench for vliw_fwd_ctrl: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a lane/stage model. Exercises StallCount when VLIW_FWD_PERF_EN is defined.
module tb_vliw_fwd_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vliw_fwd_ctrl_if #(.NLANES(4)) bus ();
  vliw_fwd_ctrl #(.NLANES(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;
  bit cnt_chk = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what instruction occupies each lane slot of each stage.
  typedef struct packed {
    logic [4:0] rd;
    logic       rw;
    logic       late;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } slot_t;
  slot_t me[4], mm[4], mw[4];
  longint unsigned m_count;

  function automatic bit exp_lu();
    exp_lu = 1'b0;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++)
        if (me[j].rw && me[j].late && me[j].rd != 0 &&
            (me[j].rd == bus.Rs1D[i] || me[j].rd == bus.Rs2D[i]))
          exp_lu = 1'b1;
  endfunction

  function automatic bit exp_mwe();
    exp_mwe = 1'b0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        if (a != b) begin
          if (mm[a].rw && mm[b].rw && mm[a].rd != 0 && mm[a].rd == mm[b].rd) exp_mwe = 1'b1;
          if (mw[a].rw && mw[b].rw && mw[a].rd != 0 && mw[a].rd == mw[b].rd) exp_mwe = 1'b1;
        end
  endfunction

  // Search highest lane first: M (non-late) beats W beats register file.
  task automatic exp_fwd(input int i, input logic [4:0] x, output logic [1:0] f, output logic [1:0] s);
    int src;
    src = i;
    f = 2'b00;
    if (x != 0) begin
      for (int j = 3; j >= 0; j--)
        if (f == 2'b00 && mm[j].rw && !mm[j].late && mm[j].rd == x) begin f = 2'b10; src = j; end
      for (int j = 3; j >= 0; j--)
        if (f == 2'b00 && mw[j].rw && mw[j].rd == x) begin f = 2'b01; src = j; end
    end
    s = 2'((src - i + 4) % 4);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        me[i] <= '0;
        mm[i] <= '0;
        mw[i] <= '0;
      end
      m_count <= 0;
    end else begin
      if (exp_lu() && m_count < 64'hFFFF_FFFF) m_count <= m_count + 1;
      for (int i = 0; i < 4; i++) begin
        if (bus.FlushW) mw[i] <= '0;
        else if (!bus.StallW) mw[i] <= mm[i];
        if (bus.FlushM) mm[i] <= '0;
        else if (!bus.StallM) mm[i] <= me[i];
        if (bus.FlushE) me[i] <= '0;
        else if (!bus.StallE)
          me[i] <= '{rd: bus.RdD[i], rw: bus.RegWriteD[i], late: bus.LateResultD[i],
                     rs1: bus.Rs1D[i], rs2: bus.Rs2D[i]};
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] f, s;
    for (int i = 0; i < 4; i++) begin
      exp_fwd(i, me[i].rs1, f, s);
      chk($sformatf("ForwardAE[%0d]", i), 32'(bus.ForwardAE[i]), 32'(f));
      chk($sformatf("ForwardSelAE[%0d]", i), 32'(bus.ForwardSelAE[i]), 32'(s));
      exp_fwd(i, me[i].rs2, f, s);
      chk($sformatf("ForwardBE[%0d]", i), 32'(bus.ForwardBE[i]), 32'(f));
      chk($sformatf("ForwardSelBE[%0d]", i), 32'(bus.ForwardSelBE[i]), 32'(s));
    end
    chk("LoadUseStallD", 32'(bus.LoadUseStallD), 32'(exp_lu()));
    chk("MultiWriteErr", 32'(bus.MultiWriteErr), 32'(exp_mwe()));
`ifdef VLIW_FWD_PERF_EN
    if (cnt_chk) chk("StallCount", bus.StallCount, 32'(m_count));
`endif
  end

  task automatic clear_d();
    bus.Rs1D = '0;
    bus.Rs2D = '0;
    bus.RdD = '0;
    bus.RegWriteD = '0;
    bus.LateResultD = '0;
  endtask

  task automatic clear_ctl();
    {bus.StallE, bus.FlushE, bus.StallM, bus.FlushM, bus.StallW, bus.FlushW} = '0;
  endtask

  task automatic set_lane(input int l, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic late);
    bus.Rs1D[l] = rs1;
    bus.Rs2D[l] = rs2;
    bus.RdD[l] = rd;
    bus.RegWriteD[l] = rw;
    bus.LateResultD[l] = late;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    clear_d();
    clear_ctl();
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_d();
    clear_ctl();
    #12 reset = 1'b0;
    @(negedge clk);
    chk("reset ForwardAE", 32'(bus.ForwardAE), 32'd0);
    chk("reset ForwardSelBE", 32'(bus.ForwardSelBE), 32'd0);

    // Lane 0 writes x5 (M), lane 2 reads rs1=x5 (E): M forward, select 2.
    tick(); set_lane(0, 0, 0, 5, 1, 0);
    tick(); clear_d(); set_lane(2, 5, 0, 0, 0, 0);
    tick(); clear_d();
    @(negedge clk);
    chk("t1 ForwardAE[2]", 32'(bus.ForwardAE[2]), 32'd2);
    chk("t1 ForwardSelAE[2]", 32'(bus.ForwardSelAE[2]), 32'd2);

    // Lane 3 writes x7 (W), lane 1 reads rs2=x7: W forward, select 2.
    tick(); set_lane(3, 0, 0, 7, 1, 0);
    tick(); clear_d();
    tick(); set_lane(1, 0, 7, 0, 0, 0);
    tick(); clear_d();
    @(negedge clk);
    chk("t2 ForwardBE[1]", 32'(bus.ForwardBE[1]), 32'd1);
    chk("t2 ForwardSelBE[1]", 32'(bus.ForwardSelBE[1]), 32'd2);

    // Lane 1 lw x9 in E, lane 0 reads x9 in D: one stall cycle, then W forward.
    do_reset();
    tick(); set_lane(1, 0, 0, 9, 1, 1);
    tick(); clear_d(); set_lane(0, 9, 0, 0, 0, 0);
    @(negedge clk);
    chk("t3 LoadUseStallD on", 32'(bus.LoadUseStallD), 32'd1);
    bus.FlushE = 1'b1;
    tick(); bus.FlushE = 1'b0;
    @(negedge clk);
    chk("t3 LoadUseStallD off", 32'(bus.LoadUseStallD), 32'd0);
    tick(); clear_d();
    @(negedge clk);
    chk("t3 ForwardAE[0]", 32'(bus.ForwardAE[0]), 32'd1);
    chk("t3 ForwardSelAE[0]", 32'(bus.ForwardSelAE[0]), 32'd1);
`ifdef VLIW_FWD_PERF_EN
    chk("t3 StallCount", bus.StallCount, 32'd1);
`endif

    // Lanes 1 and 3 both write x4; lane 2 writes x0 as a late op.
    tick(); set_lane(1, 0, 0, 4, 1, 0); set_lane(3, 0, 0, 4, 1, 0); set_lane(2, 0, 0, 0, 1, 1);
    tick(); clear_d(); set_lane(0, 4, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4 LoadUseStallD x0", 32'(bus.LoadUseStallD), 32'd0);
    tick(); clear_d();
    @(negedge clk);
    chk("t4 MultiWriteErr", 32'(bus.MultiWriteErr), 32'd1);
    chk("t4 ForwardAE[0]", 32'(bus.ForwardAE[0]), 32'd2);
    chk("t4 ForwardSelAE[0]", 32'(bus.ForwardSelAE[0]), 32'd3);
    chk("t4 ForwardBE[0]", 32'(bus.ForwardBE[0]), 32'd0);

    // Reset mid-stall with W/M/E populated.
    tick(); set_lane(0, 0, 0, 3, 1, 0);
    tick(); clear_d(); set_lane(1, 0, 0, 6, 1, 1);
    tick(); clear_d(); set_lane(2, 0, 0, 8, 1, 1);
    tick(); clear_d(); set_lane(3, 8, 3, 0, 0, 0); set_lane(0, 6, 3, 0, 0, 0);
    @(negedge clk);
    chk("t5 LoadUseStallD pre", 32'(bus.LoadUseStallD), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t5 ForwardAE", 32'(bus.ForwardAE), 32'd0);
    chk("t5 ForwardBE", 32'(bus.ForwardBE), 32'd0);
    chk("t5 ForwardSelAE", 32'(bus.ForwardSelAE), 32'd0);
    chk("t5 ForwardSelBE", 32'(bus.ForwardSelBE), 32'd0);
    chk("t5 LoadUseStallD", 32'(bus.LoadUseStallD), 32'd0);
    chk("t5 MultiWriteErr", 32'(bus.MultiWriteErr), 32'd0);
`ifdef VLIW_FWD_PERF_EN
    chk("t5 StallCount", bus.StallCount, 32'd0);
`endif
    #1 reset = 1'b0;
    clear_d(); set_lane(0, 3, 6, 0, 0, 0);
    tick(); clear_d();
    @(negedge clk);
    chk("t5 post ForwardAE", 32'(bus.ForwardAE), 32'd0);
    chk("t5 post ForwardBE", 32'(bus.ForwardBE), 32'd0);

    // Random traffic with small register range to force collisions.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int l = 0; l < 4; l++)
        set_lane(l, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 1'($urandom % 2), 1'($urandom_range(0, 3) == 0));
      bus.StallE = ($urandom_range(0, 7) == 0);
      bus.FlushE = ($urandom_range(0, 9) == 0);
      bus.StallM = ($urandom_range(0, 9) == 0);
      bus.FlushM = ($urandom_range(0, 11) == 0);
      bus.StallW = ($urandom_range(0, 9) == 0);
      bus.FlushW = ($urandom_range(0, 11) == 0);
    end

`ifdef VLIW_FWD_PERF_EN
    // Saturation: preload near the top and hold the load-use condition.
    do_reset();
    tick(); set_lane(1, 0, 0, 9, 1, 1);
    tick(); clear_d(); set_lane(0, 9, 0, 0, 0, 0); bus.StallE = 1'b1;
    cnt_chk = 1'b0;
    @(negedge clk);
    force dut.stall_count_reg = 32'hFFFF_FFFA;
    #1 release dut.stall_count_reg;
    repeat (3) tick();
    @(negedge clk);
    chk("sat StallCount step", bus.StallCount, 32'hFFFF_FFFD);
    repeat (10) tick();
    @(negedge clk);
    chk("sat StallCount hold", bus.StallCount, 32'hFFFF_FFFF);
    chk("sat LoadUseStallD", 32'(bus.LoadUseStallD), 32'd1);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
